// File: rtl/posit_accumulator.sv
`timescale 1ns/1ps
// posit_accumulator: reduces each in_last-terminated packet of posits to one sum by pairing held, returning and new operands on a shared fixed-latency adder; valid/ready in/out streams plus adder issue (add_in1/add_in2/add_start) and return (add_result/add_inf/add_zero/add_done) ports
module posit_accumulator #(
  parameter int NBITS = 32,
  parameter int ADD_LATENCY = 4,
  parameter int CNT_W = $clog2(ADD_LATENCY + 1) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [NBITS-1:0] out_data,
  output logic             out_inf,
  output logic [NBITS-1:0] add_in1,
  output logic [NBITS-1:0] add_in2,
  output logic             add_start,
  input  logic [NBITS-1:0] add_result,
  input  logic             add_inf,
  input  logic             add_zero,
  input  logic             add_done
);
  localparam logic [NBITS-1:0] NAR = {1'b1, {(NBITS-1){1'b0}}};
  typedef enum logic [1:0] {ACCUM, DRAIN, OUT} state_t;
  state_t state, state_n;
  logic [NBITS-1:0] hold;
  logic hold_valid, inf_sticky, r, acc_in, fire, take, unused_zero;
  logic [CNT_W-1:0] inflight, discard;
  assign unused_zero = add_zero;
  assign r = add_done & (discard == '0);
  assign in_ready = (state == ACCUM) & (discard == '0) & ~(hold_valid & r);
  assign acc_in = in_valid & in_ready;
  assign add_start = (hold_valid & r) | (hold_valid & acc_in) | (r & acc_in);
  assign add_in1 = hold_valid ? hold : add_result;
  assign add_in2 = (hold_valid & r) ? add_result : in_data;
  assign fire = (state == DRAIN) & hold_valid & (inflight == '0) & ~r;
  assign take = out_valid & out_ready;
  always_comb
    state_n = (state == ACCUM && acc_in && in_last) ? DRAIN :
              (state == DRAIN && fire) ? OUT :
              (state == OUT && take) ? ACCUM : state;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ACCUM;
      hold_valid <= 1'b0;
      inflight <= '0;
      inf_sticky <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_inf <= 1'b0;
      discard <= CNT_W'(ADD_LATENCY);
    end else begin
      state <= state_n;
      discard <= discard - CNT_W'(discard != '0);
      inflight <= inflight + CNT_W'(add_start) - CNT_W'(r);
      hold_valid <= add_start ? 1'b0 : (r | acc_in) ? 1'b1 : fire ? 1'b0 : hold_valid;
      inf_sticky <= take ? 1'b0 : inf_sticky | (acc_in & (in_data == NAR)) | (r & add_inf);
      out_valid <= fire | (out_valid & ~out_ready);
      if (fire) begin
        out_data <= inf_sticky ? NAR : hold;
        out_inf <= inf_sticky;
      end
    end
  end
  always_ff @(posedge clk)
    if (~add_start & (r | acc_in)) hold <= r ? add_result : in_data;
  always_ff @(posedge clk)
    if (!reset) begin
      assert (inflight <= CNT_W'(ADD_LATENCY));
      assert (!r || add_zero == (add_result == '0));
    end
endmodule

// File: tb/tb_posit_accumulator.sv
`timescale 1ns/1ps
// tb_posit_accumulator: directed bench with a real-valued posit adder and packet-sum scoreboard
module tb_posit_accumulator;
  localparam logic [31:0] NAR = 32'h8000_0000;
  localparam logic [31:0] ONE = 32'h4000_0000;
  localparam logic [31:0] TWO = 32'h4800_0000;
  localparam logic [31:0] THREE = 32'h4C00_0000;
  logic clk = 0, reset = 1, in_valid = 0, in_last = 0, out_ready = 1;
  logic [31:0] in_data = 0;
  logic in_ready, out_valid, out_inf, add_start, add_inf, add_zero, add_done;
  logic [31:0] out_data, add_in1, add_in2, add_result;
  int checks = 0, failures = 0;

  posit_accumulator dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inf(out_inf), .add_in1(add_in1), .add_in2(add_in2), .add_start(add_start),
    .add_result(add_result), .add_inf(add_inf), .add_zero(add_zero), .add_done(add_done)
  );

  always #5 clk = ~clk;

  function automatic real pow2(input int x);
    real v = 1.0;
    if (x >= 0) for (int i = 0; i < x; i++) v = v * 2.0;
    else for (int i = 0; i < -x; i++) v = v / 2.0;
    return v;
  endfunction

  function automatic real p_dec(input logic [31:0] p);
    logic [31:0] q;
    int i, k, e;
    real f, sc;
    if (p == 32'h0) return 0.0;
    q = p[31] ? -p : p;
    i = 30;
    k = q[30] ? -1 : 0;
    while (i >= 0 && q[i] == q[30]) begin
      k = q[30] ? k + 1 : k - 1;
      i--;
    end
    i--;
    e = 0;
    for (int j = 0; j < 2; j++) begin
      e = 2 * e + ((i >= 0) ? int'(q[i]) : 0);
      i--;
    end
    f = 1.0;
    sc = 0.5;
    while (i >= 0) begin
      if (q[i]) f = f + sc;
      sc = sc / 2.0;
      i--;
    end
    f = f * pow2(4 * k + e);
    return p[31] ? -f : f;
  endfunction

  function automatic logic [31:0] p_enc(input real v);
    logic [63:0] w;
    logic [30:0] p;
    real m;
    int s, k, e, n;
    bit neg, g, st;
    if (v == 0.0) return 32'h0;
    neg = v < 0.0;
    m = neg ? -v : v;
    s = 0;
    while (m >= 2.0) begin m = m / 2.0; s++; end
    while (m < 1.0) begin m = m * 2.0; s--; end
    if (s > 120) begin s = 120; m = 1.0; end
    if (s < -120) begin s = -120; m = 1.0; end
    k = (s >= 0) ? s / 4 : -((3 - s) / 4);
    e = s - 4 * k;
    w = '0;
    n = 0;
    if (k >= 0) begin
      for (int i = 0; i <= k; i++) begin w[63 - n] = 1'b1; n++; end
      n++;
    end else begin
      n = -k;
      w[63 - n] = 1'b1;
      n++;
    end
    w[63 - n] = e[1]; n++;
    w[63 - n] = e[0]; n++;
    m = m - 1.0;
    while (n < 64) begin
      m = m * 2.0;
      if (m >= 1.0) begin w[63 - n] = 1'b1; m = m - 1.0; end
      n++;
    end
    p = w[63:33];
    g = w[32];
    st = (w[31:0] != 0) || (m != 0.0);
    if (g && (st || p[0])) p = p + 31'd1;
    if (p == '0) p = '1;
    return neg ? -{1'b0, p} : {1'b0, p};
  endfunction

  function automatic logic [31:0] p_add(input logic [31:0] a, input logic [31:0] b);
    return (a == NAR || b == NAR) ? NAR : p_enc(p_dec(a) + p_dec(b));
  endfunction

  logic [3:0] pv = '0;
  logic [31:0] pr [0:3];
  always @(posedge clk) begin
    pv <= {pv[2:0], add_start};
    pr[0] <= p_add(add_in1, add_in2);
    for (int i = 1; i < 4; i++) pr[i] <= pr[i-1];
  end
  assign add_done = pv[3];
  assign add_result = pr[3];
  assign add_inf = pr[3] == NAR;
  assign add_zero = pr[3] == 32'h0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  logic [32:0] exp_q[$];
  real acc = 0.0;
  bit acc_nar = 0, pv_valid = 0, pv_ready = 0;
  logic [31:0] pv_data = 0;
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      acc = 0.0;
      acc_nar = 0;
      pv_valid = 0;
    end else begin
      if (in_valid && in_ready) begin
        if (in_data == NAR) acc_nar = 1;
        else acc = acc + p_dec(in_data);
        if (in_last) begin
          exp_q.push_back(acc_nar ? {1'b1, NAR} : {1'b0, p_enc(acc)});
          acc = 0.0;
          acc_nar = 0;
        end
      end
      if (pv_valid && !pv_ready) begin
        chk("out_valid_held", 32'(out_valid), 32'd1);
        chk("out_data_stable", out_data, pv_data);
      end
      if (out_valid) begin
        chk("in_ready_while_out", 32'(in_ready), 32'd0);
        if (out_ready) begin
          if (exp_q.size() == 0) chk("spurious_out", 32'(out_valid), 32'd0);
          else begin
            chk("model_out_data", out_data, exp_q[0][31:0]);
            chk("model_out_inf", 32'(out_inf), 32'(exp_q[0][32]));
            void'(exp_q.pop_front());
          end
        end
      end
      pv_valid = out_valid;
      pv_ready = out_ready;
      pv_data = out_data;
    end
  end

  logic [31:0] vals [0:15];
  logic st [0:63], ir [0:63], ov [0:63], oi [0:63];
  logic [31:0] od [0:63], a1 [0:63], a2 [0:63];

  task automatic stream(input int n, input int ncyc, input int rst_at);
    int idx = 0;
    bit stop = 0;
    for (int c = 0; c < ncyc; c++) begin
      reset = (c == rst_at);
      if (reset) stop = 1;
      in_valid = !stop && idx < n;
      in_data = (idx < n) ? vals[idx] : 32'h0;
      in_last = in_valid && idx == n - 1;
      @(negedge clk);
      st[c] = add_start; ir[c] = in_ready; ov[c] = out_valid; oi[c] = out_inf;
      od[c] = out_data; a1[c] = add_in1; a2[c] = add_in2;
      if (in_valid && in_ready && !reset) idx++;
      @(posedge clk); #1;
    end
    reset = 0; in_valid = 0; in_last = 0;
  endtask

  task automatic do_reset;
    reset = 1; in_valid = 0; in_last = 0;
    @(posedge clk); #1;
    reset = 0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_inf", 32'(out_inf), 32'd0);
    chk("rst_in_ready_discard", 32'(in_ready), 32'd0);
    chk("rst_add_start", 32'(add_start), 32'd0);
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n = 0;
    in_valid = 1; in_data = d; in_last = l;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic wait_out;
    int n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("out_timeout", 32'(out_valid), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int gaps [0:7] = '{0, 2, 1, 0, 3, 0, 1, 2};
    int cnt;
    do_reset();
    for (int i = 0; i < 4; i++) vals[i] = ONE;
    stream(4, 20, -1);
    for (int c = 0; c < 20; c++) begin
      chk($sformatf("t1_add_start_c%0d", c), 32'(st[c]), 32'(c == 1 || c == 3 || c == 7));
      chk($sformatf("t1_out_valid_c%0d", c), 32'(ov[c]), 32'(c == 13));
    end
    for (int c = 0; c < 4; c++) chk($sformatf("t1_in_ready_c%0d", c), 32'(ir[c]), 32'd1);
    chk("t1_sum", od[13], 32'h5000_0000);
    chk("t1_inf", 32'(oi[13]), 32'd0);
    vals[0] = THREE;
    stream(1, 6, -1);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("t2_add_start_c%0d", c), 32'(st[c]), 32'd0);
      chk($sformatf("t2_out_valid_c%0d", c), 32'(ov[c]), 32'(c == 2));
    end
    chk("t2_data", od[2], THREE);
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      send(ONE, i == 7);
      repeat (gaps[i]) begin @(posedge clk); #1; end
    end
    wait_out();
    for (int i = 0; i < 10; i++) begin
      chk("t3_hold_data", out_data, 32'h5800_0000);
      chk("t3_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
    end
    @(posedge clk); #1;
    out_ready = 1;
    @(negedge clk);
    chk("t3_valid_at_take", 32'(out_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t3_valid_after", 32'(out_valid), 32'd0);
    chk("t3_ready_after", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    send(ONE, 0); send(NAR, 0); send(TWO, 1);
    wait_out();
    chk("t4_nar_data", out_data, NAR);
    chk("t4_nar_inf", 32'(out_inf), 32'd1);
    @(posedge clk); #1;
    send(ONE, 0); send(ONE, 1);
    wait_out();
    chk("t4_next_data", out_data, TWO);
    chk("t4_next_inf", 32'(out_inf), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) vals[i] = ONE;
    stream(8, 16, 3);
    chk("t5_first_add", 32'(st[1]), 32'd1);
    for (int c = 0; c < 16; c++) chk($sformatf("t5_out_valid_c%0d", c), 32'(ov[c]), 32'd0);
    for (int c = 4; c < 16; c++) chk($sformatf("t5_add_start_c%0d", c), 32'(st[c]), 32'd0);
    for (int c = 4; c < 9; c++) chk($sformatf("t5_in_ready_c%0d", c), 32'(ir[c]), 32'(c == 8));
    vals[0] = TWO; vals[1] = TWO;
    stream(2, 12, -1);
    chk("t5_next_valid", 32'(ov[7]), 32'd1);
    chk("t5_next_data", od[7], 32'h5000_0000);
    for (int i = 0; i < 8; i++) vals[i] = (i == 4) ? THREE : ONE;
    stream(8, 40, -1);
    chk("t6_in_ready_c5", 32'(ir[5]), 32'd0);
    chk("t6_add_start_c5", 32'(st[5]), 32'd1);
    chk("t6_add_in1_c5", a1[5], THREE);
    chk("t6_add_in2_c5", a2[5], TWO);
    chk("t6_in_ready_c6", 32'(ir[6]), 32'd1);
    cnt = 0;
    for (int c = 0; c < 40; c++)
      if (ov[c]) begin
        cnt++;
        chk("t6_sum", od[c], 32'h5A00_0000);
      end
    chk("t6_out_count", 32'(cnt), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/posit_accumulator.md
Name: posit_accumulator

Overview:
- Streaming reduction stage wrapped around the 4-stage posit adder (positadd_4).
- Accepts a packet of 32-bit posits terminated by in_last and sums them to a single posit.
- Keeps the adder pipeline busy by pairing any two available operands: a held value, a returning adder result, or a new input.
- Emits one result per packet on a valid/ready output.

Parameters:
NBITS, 32, posit width
ADD_LATENCY, 4, cycles from add_start to add_done (fixed adder latency)
CNT_W, $clog2(ADD_LATENCY+1)+1, width of the in-flight and discard counters

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  input posit valid
in_ready  out  1  input accepted when in_valid & in_ready
in_data  in  NBITS  input posit
in_last  in  1  last element of packet (qualified by the handshake)
out_valid  out  1  sum valid
out_ready  in  1  consumer accepts sum
out_data  out  NBITS  packet sum
out_inf  out  1  sum is NaR
add_in1  out  NBITS  adder operand 1 (combinational)
add_in2  out  NBITS  adder operand 2 (combinational)
add_start  out  1  issue add this cycle (combinational)
add_result  in  NBITS  adder result
add_inf  in  1  adder NaR flag
add_zero  in  1  adder zero flag (unused except for checking)
add_done  in  1  add_result valid, exactly ADD_LATENCY cycles after its add_start

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Reset values: state=ACCUM, hold_valid=0, inflight=0, inf_sticky=0, out_valid=0, out_data=0, out_inf=0. discard counter loads ADD_LATENCY.
- Discard: while the discard counter is nonzero it decrements each cycle, and add_done is ignored. The adder has no reset, so stale results after a mid-operation reset are dropped.
- States: ACCUM (taking input), DRAIN (in_last seen, reducing the remainder), OUT (holding the result).
- in_ready = (state==ACCUM) & (discard==0) & ~(hold_valid & R), where R = add_done & (discard==0).
- Operand pairing, per cycle (I = input handshake):
  - R & H: add(hold, result); hold clears.
  - R & I, hold empty: add(result, in_data).
  - H & I: add(hold, in_data); hold clears.
  - Exactly one of R or I: that value loads hold.
  - Nothing available: idle.
  - Operand order on add_in1/add_in2 is as listed; at most one add per cycle; hold never overflows.
- Counters and flags:
  - inflight += add_start, -= R. inflight ≤ ADD_LATENCY is an assertion.
  - inf_sticky |= (I & in_data==0x80000000) | (R & add_inf).
- Transitions:
  - ACCUM→DRAIN on an accepted in_last, after applying that cycle's pairing.
  - DRAIN→OUT when hold_valid & inflight==0 & ~R. In that cycle out_data ← inf_sticky ? 0x80000000 : hold, out_inf ← inf_sticky, and hold clears. out_valid=1 from the next cycle.
  - OUT: out_valid and out_data are stable until out_ready. On the handshake, out_valid←0, inf_sticky←0, state←ACCUM, and a new packet may be accepted the following cycle.
- A single-element packet outputs the element unchanged (no add issued); out_valid rises 2 cycles after acceptance.
- Posit zero operands go through the adder normally.
- Reduction order depends on arrival timing but is deterministic for a given stimulus timing.
- Reset in any state, including mid-packet or during OUT, aborts the packet without emitting output.

Test Plan:
- Four × 1.0 (0x40000000), in_valid continuous from cycle 0, last at cycle 3, out_ready=1, real 4-stage adder → adds issued at cycles 1, 3, 7; out_valid at cycle 13; out_data=0x50000000 (4.0); out_inf=0.
- Single element 0x4C000000 (3.0) with last → no add_start; out_valid 2 cycles after acceptance; out_data=0x4C000000.
- Eight × 1.0 with random in_valid gaps and out_ready held low 10 cycles → out_data=0x58000000 (8.0), held stable while out_ready=0; in_ready=0 until the handshake; inflight never exceeds 4.
- Packet {1.0, 0x80000000, 2.0} → out_data=0x80000000, out_inf=1; the next packet {1.0, 1.0} → 0x48000000 with out_inf=0.
- Assert reset 2 cycles after the first add_start of an 8-element packet → out_valid stays 0; add_done arriving within 4 cycles after reset is ignored. The following packet {2.0, 2.0} → 0x50000000.
- Simultaneous hold_valid & add_done while in_valid=1 → in_ready=0 that cycle, add(hold, result) is issued, and the input is accepted the next cycle.
